// File: rtl/tick_timer_scheduler_if.sv
// Request/grant bundle between the clients and the shared tick timer.
// The master side (clients plus the slow-clock divider) drives requests, durations,
// cancel and the tick enable. The slave side (the timer) drives ownership and status.
interface tick_timer_scheduler_if #(
    parameter int unsigned CNT_W = 8
);
    logic                 tick_in;
    logic [3:0]           req;
    logic [4*CNT_W-1:0]   dur_in;
    logic                 cancel;
    logic [3:0]           gnt;
    logic                 busy;
    logic [3:0]           done;
    logic [CNT_W-1:0]     remaining;

    modport master (
        output tick_in,
        output req,
        output dur_in,
        output cancel,
        input  gnt,
        input  busy,
        input  done,
        input  remaining
    );

    modport slave (
        input  tick_in,
        input  req,
        input  dur_in,
        input  cancel,
        output gnt,
        output busy,
        output done,
        output remaining
    );
endinterface

// File: rtl/tick_timer_scheduler.sv
// Shared tick timer for four clients.
// A round-robin arbiter hands the timer to one requester at a time. The owner's duration
// is loaded at grant and counted down on 4 Hz ticks. Completion gives the owner a
// one-cycle done pulse. Cancel, a dropped request or reset aborts silently.
module tick_timer_scheduler #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk_in,
    input  logic                  rst,
    tick_timer_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;

    logic             win_valid;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             abort;
    logic [CNT_W-1:0] dur_arr [4];

    // Slice the packed duration bus into one entry per client.
    for (genvar i = 0; i < 4; i++) begin : g_dur
        assign dur_arr[i] = bus.dur_in[i*CNT_W +: CNT_W];
    end

    // Round-robin search starting at the client after the last one served.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        cand      = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // The owner withdrawing its request counts the same as an explicit cancel.
    always_comb begin
        abort = bus.cancel || !bus.req[owner_q];
    end

    // Next-state logic. Abort beats the final tick, and last_q only moves when RUN is left.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        remaining_d = remaining_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    owner_d     = win_idx;
                    remaining_d = dur_arr[win_idx];
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d     = StIdle;
                    remaining_d = '0;
                    last_d      = owner_q;
                end else if (remaining_q == '0) begin
                    // Zero-length interval completes without waiting for a tick.
                    state_d = StDone;
                    last_d  = owner_q;
                end else if (bus.tick_in) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDone;
                        last_d  = owner_q;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d     = StIdle;
                remaining_d = '0;
            end
        endcase
    end

    // State registers with synchronous reset; client 0 has first priority out of reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 2'd0;
            last_q      <= 2'd3;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs decode directly from registered state, so they are glitch-free.
    always_comb begin
        bus.gnt       = 4'b0000;
        bus.done      = 4'b0000;
        bus.busy      = 1'b0;
        bus.remaining = remaining_q;
        if (state_q == StRun) begin
            bus.gnt  = 4'b0001 << owner_q;
            bus.busy = 1'b1;
        end
        if (state_q == StDone) begin
            bus.done = 4'b0001 << owner_q;
        end
    end

    a_gnt_onehot : assert property (@(posedge clk_in) $onehot0(bus.gnt));
    a_done_onehot : assert property (@(posedge clk_in) $onehot0(bus.done));
    a_done_not_owned : assert property (@(posedge clk_in) (|bus.done) |-> (bus.gnt == 4'b0000));

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Directed bench for tick_timer_scheduler: a per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_tick_timer_scheduler;

    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst;

    tick_timer_scheduler_if #(.CNT_W(CNT_W)) bus ();

    tick_timer_scheduler #(.CNT_W(CNT_W)) dut (
        .clk_in (clk),
        .rst    (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        tick;
        logic [3:0]  req;
        logic        cancel;
        logic [31:0] dur;
        logic [3:0]  gnt;
        logic        busy;
        logic [3:0]  done;
        logic [7:0]  rem;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    int n_pass  = 0;
    int n_check = 0;

    function automatic vec_t mk(input logic r, input logic t, input logic [3:0] q,
                                input logic c, input logic [31:0] d, input logic [3:0] g,
                                input logic b, input logic [3:0] dn, input logic [7:0] rm);
        vec_t v;
        v.rst = r; v.tick = t; v.req = q; v.cancel = c; v.dur = d;
        v.gnt = g; v.busy = b; v.done = dn; v.rem = rm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_check++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Outputs packed as {gnt, busy, done, remaining}.
    function automatic logic [31:0] outs();
        return {15'd0, bus.gnt, bus.busy, bus.done, bus.remaining};
    endfunction

    function automatic logic [31:0] pack(input logic [3:0] g, input logic b,
                                         input logic [3:0] dn, input logic [7:0] rm);
        return {15'd0, g, b, dn, rm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic t, input logic [3:0] q, input logic c,
                         input logic [31:0] d);
        rst = r; bus.tick_in = t; bus.req = q; bus.cancel = c; bus.dur_in = d;
    endtask

    initial begin
        logic [31:0] dA, dB, dRR, dRst, dMax;
        dA   = {8'd1, 8'd5, 8'd0, 8'd3};
        dB   = {8'd1, 8'd9, 8'd0, 8'd3};
        dRR  = {8'd1, 8'd1, 8'd1, 8'd1};
        dRst = {8'd7, 8'd6, 8'd1, 8'd1};
        dMax = {8'd0, 8'd0, 8'd0, 8'd255};

        // Reset, idle cancel/tick, zero duration, abort with regrant, dur resample,
        // tick/cancel collision, normal completion and re-arbitration.
        vecs[0]  = mk(1, 1, 4'b1111, 1, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[1]  = mk(1, 0, 4'b0000, 0, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[2]  = mk(0, 1, 4'b0000, 1, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[3]  = mk(0, 0, 4'b0010, 0, dA, 4'b0010, 1, 4'b0000, 0);
        vecs[4]  = mk(0, 0, 4'b0010, 0, dA, 4'b0000, 0, 4'b0010, 0);
        vecs[5]  = mk(0, 0, 4'b0000, 0, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[6]  = mk(0, 1, 4'b0100, 0, dA, 4'b0100, 1, 4'b0000, 5);
        vecs[7]  = mk(0, 0, 4'b0100, 0, dA, 4'b0100, 1, 4'b0000, 5);
        vecs[8]  = mk(0, 1, 4'b0100, 0, dA, 4'b0100, 1, 4'b0000, 4);
        vecs[9]  = mk(0, 1, 4'b0100, 0, dA, 4'b0100, 1, 4'b0000, 3);
        vecs[10] = mk(0, 0, 4'b0100, 1, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[11] = mk(0, 0, 4'b0100, 0, dA, 4'b0100, 1, 4'b0000, 5);
        vecs[12] = mk(0, 1, 4'b0100, 0, dB, 4'b0100, 1, 4'b0000, 4);
        vecs[13] = mk(0, 0, 4'b0000, 0, dB, 4'b0000, 0, 4'b0000, 0);
        vecs[14] = mk(0, 0, 4'b1000, 0, dA, 4'b1000, 1, 4'b0000, 1);
        vecs[15] = mk(0, 1, 4'b1000, 1, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[16] = mk(0, 0, 4'b0000, 0, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[17] = mk(0, 0, 4'b1000, 0, dA, 4'b1000, 1, 4'b0000, 1);
        vecs[18] = mk(0, 1, 4'b1000, 0, dA, 4'b0000, 0, 4'b1000, 0);
        vecs[19] = mk(0, 0, 4'b1000, 1, dA, 4'b0000, 0, 4'b0000, 0);
        vecs[20] = mk(0, 0, 4'b1000, 0, dA, 4'b1000, 1, 4'b0000, 1);
        vecs[21] = mk(0, 0, 4'b0000, 0, dA, 4'b0000, 0, 4'b0000, 0);

        drive(1, 0, 4'b0000, 0, dA);
        step();

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].tick, vecs[i].req, vecs[i].cancel, vecs[i].dur);
            step();
            chk($sformatf("vec%0d", i), outs(),
                pack(vecs[i].gnt, vecs[i].busy, vecs[i].done, vecs[i].rem));
        end

        // Single request, dur 3, tick every 5 cycles.
        drive(1, 0, 4'b0000, 0, dA);
        step();
        drive(0, 0, 4'b0001, 0, dA);
        step();
        chk("single_grant", outs(), pack(4'b0001, 1, 4'b0000, 3));
        for (int t = 1; t <= 3; t++) begin
            for (int w = 0; w < 4; w++) begin
                step();
                chk("single_hold", outs(), pack(4'b0001, 1, 4'b0000, 8'(4 - t)));
            end
            bus.tick_in = 1'b1;
            step();
            bus.tick_in = 1'b0;
            if (t < 3) chk("single_tick", outs(), pack(4'b0001, 1, 4'b0000, 8'(3 - t)));
            else       chk("single_done", outs(), pack(4'b0000, 0, 4'b0001, 0));
        end
        bus.req = 4'b0000;
        step();
        chk("single_done_once", outs(), pack(4'b0000, 0, 4'b0000, 0));

        // Round robin with every client requesting, dur 1 each.
        drive(1, 0, 4'b0000, 0, dRR);
        step();
        drive(0, 0, 4'b1111, 0, dRR);
        for (int g = 0; g < 5; g++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (g % 4);
            step();
            chk($sformatf("rr_gnt%0d", g), outs(), pack(exp_g, 1, 4'b0000, 1));
            bus.tick_in = 1'b1;
            step();
            bus.tick_in = 1'b0;
            chk($sformatf("rr_done%0d", g), outs(), pack(4'b0000, 0, exp_g, 0));
            step();
            chk($sformatf("rr_idle%0d", g), outs(), pack(4'b0000, 0, 4'b0000, 0));
        end

        // Reset mid-run, then arbitration restarts from client 0.
        drive(0, 0, 4'b0100, 0, dRst);
        step();
        chk("rst_run_gnt", outs(), pack(4'b0100, 1, 4'b0000, 6));
        bus.tick_in = 1'b1;
        step();
        step();
        bus.tick_in = 1'b0;
        chk("rst_run_rem4", outs(), pack(4'b0100, 1, 4'b0000, 4));
        drive(1, 1, 4'b1001, 0, dRst);
        step();
        chk("rst_all_zero", outs(), pack(4'b0000, 0, 4'b0000, 0));
        drive(0, 0, 4'b1001, 0, dRst);
        step();
        chk("rst_first_prio", outs(), pack(4'b0001, 1, 4'b0000, 1));
        drive(0, 0, 4'b0000, 0, dRst);
        step();
        drive(1, 0, 4'b0000, 0, dRst);
        step();
        drive(0, 0, 4'b1000, 0, dRst);
        step();
        chk("rst_req3", outs(), pack(4'b1000, 1, 4'b0000, 7));
        bus.req = 4'b0000;
        step();

        // Maximum duration takes exactly 255 ticks.
        drive(0, 0, 4'b0001, 0, dMax);
        step();
        chk("max_load", outs(), pack(4'b0001, 1, 4'b0000, 255));
        bus.tick_in = 1'b1;
        for (int t = 0; t < 254; t++) step();
        chk("max_rem1", outs(), pack(4'b0001, 1, 4'b0000, 1));
        step();
        bus.tick_in = 1'b0;
        chk("max_done", outs(), pack(4'b0000, 0, 4'b0001, 0));
        bus.req = 4'b0000;
        step();
        chk("max_idle", outs(), pack(4'b0000, 0, 4'b0000, 0));

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule

// File: doc/tick_timer_scheduler.md
TICK_TIMER_SCHEDULER -- requirements
Module: tick_timer_scheduler

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of each requested duration in ticks.
REQ-002 The block SHALL have port clk_in, input, 1 bit, system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port tick_in, input, 1 bit, the one-cycle 4 Hz enable pulse from the slow-clock divider.
REQ-005 The block SHALL have port req, input, 4 bits, one timed-interval request per client (bit i = client i), level-held.
REQ-006 The block SHALL have port dur_in, input, 4*CNT_W bits, the duration for client i at bits [i*CNT_W +: CNT_W].
REQ-007 The block SHALL have port cancel, input, 1 bit, which aborts the running interval.
REQ-008 The block SHALL have port gnt, output, 4 bits, one-hot owner of the shared timer; all zero when the timer is free.
REQ-009 The block SHALL have port busy, output, 1 bit, high while an interval is owned (state RUN).
REQ-010 The block SHALL have port done, output, 4 bits, a one-cycle completion pulse to the owning client.
REQ-011 The block SHALL have port remaining, output, CNT_W bits, the live tick count of the running interval.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with req != 0, the block SHALL register gnt one-hot to the winner, load remaining with the winner's dur_in, and enter RUN on the next edge (grant latency 1 cycle).
REQ-014 Arbitration SHALL be round-robin: search starts at the client after last_served (mod 4); last_served resets to 3, so client 0 has first priority.
REQ-015 last_served SHALL update to the granted client when the interval leaves RUN, whether through completion or abort.
REQ-016 If the loaded duration is 0, the block SHALL go from grant directly to DONE, i.e. done is pulsed 2 cycles after req.
REQ-017 In RUN, each tick_in SHALL decrement remaining by 1; a tick_in in the grant cycle or in IDLE/DONE SHALL be ignored.
REQ-018 When tick_in arrives with remaining == 1, the block SHALL set remaining to 0 and enter DONE.
REQ-019 In DONE, done[owner] SHALL be high for exactly one cycle, gnt and busy SHALL already be 0, and the next state SHALL be IDLE.
REQ-020 Abort SHALL occur in RUN when cancel = 1 or req[owner] = 0: go to IDLE, clear gnt, zero remaining, no done pulse.
REQ-021 If abort and the final tick occur in the same cycle, abort SHALL win and no done pulse is issued.
REQ-022 dur_in SHALL be sampled only at grant; later changes SHALL not affect the running interval.
REQ-023 A client still holding req after its done SHALL be re-arbitrated like any other, behind the other pending clients.
REQ-024 remaining SHALL never wrap below 0 or exceed 2^CNT_W-1; a duration of 2^CNT_W-1 SHALL take exactly that many ticks.
REQ-025 cancel in IDLE or DONE SHALL have no effect.

Reset
REQ-026 While rst = 1, on each clock edge the block SHALL force state = IDLE, gnt = 0, busy = 0, done = 0, remaining = 0 and last_served = 3.
REQ-027 rst asserted mid-RUN SHALL abort the interval without any done pulse.
REQ-028 Arbitration SHALL resume on the first edge after rst falls, if req is non-zero.

Verification
REQ-029 Bench scenario, single request: req = 0001, dur0 = 3, ticks every 5 cycles -> gnt = 0001 at the next edge, remaining goes 3,2,1,0, done = 0001 pulsed one cycle after the third tick, then gnt = 0.
REQ-030 Bench scenario, round robin: req = 1111 held, all durations = 1 -> grants in order 0001, 0010, 0100, 1000, 0001, with exactly one done per grant.
REQ-031 Bench scenario, abort: dur2 = 5; cancel after 2 ticks -> gnt = 0, remaining = 0, no done; with req = 0100 still held, the next grant goes to client 2 one cycle later.
REQ-032 Bench scenario, collision: remaining = 1 with tick_in and cancel in the same cycle -> no done, state IDLE.
REQ-033 Bench scenario, zero duration: dur1 = 0, req = 0010 -> gnt pulses for 1 cycle, then done = 0010 for 1 cycle, with no tick needed.
REQ-034 Bench scenario, reset mid-run: rst = 1 while remaining = 4 -> all outputs 0 next edge; after release, req = 1000 is granted to client 0's priority slot order with last_served = 3.
